// File: rtl/mbist_pkg.sv
// mbist_pkg
// Shared types and tables for the March C- memory BIST controller.
//   state_e      : controller FSM states
//   elem_e       : March C- element index (E0..E5)
//   PAT_*        : data background codes driven on bg_code[2:1]
//   elem_info_t  : per-element operation table entry
//   elem_down()  : address direction of an element
//   elem_info()  : full operation table lookup
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_OP,
        ST_CMP,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        E0,
        E1,
        E2,
        E3,
        E4,
        E5
    } elem_e;

    localparam logic [1:0] PAT_SOLID   = 2'd0;
    localparam logic [1:0] PAT_CHECKER = 2'd1;
    localparam logic [1:0] PAT_PAIR    = 2'd2;
    localparam logic [1:0] PAT_LAST    = PAT_PAIR;

    // Bit [i] of rd/pol describes operation i of the element at one address.
    typedef struct packed {
        logic       down;
        logic       two_ops;
        logic [1:0] rd;
        logic [1:0] pol;
    } elem_info_t;

    function automatic logic elem_down(input elem_e e);
        return (e == E3) || (e == E4);
    endfunction

    function automatic elem_info_t elem_info(input elem_e e);
        elem_info_t info;
        info = '0;
        info.down = elem_down(e);
        case (e)
            E0:      begin info.two_ops = 1'b0; info.rd = 2'b00; info.pol = 2'b00; end
            E1, E3:  begin info.two_ops = 1'b1; info.rd = 2'b01; info.pol = 2'b10; end
            E2, E4:  begin info.two_ops = 1'b1; info.rd = 2'b01; info.pol = 2'b01; end
            E5:      begin info.two_ops = 1'b0; info.rd = 2'b01; info.pol = 2'b00; end
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen
// Loadable up/down address counter for the march controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : preload to the first address of a new element
//   load_down  : direction of the element being loaded (1 = start at top)
//   step       : advance one address in direction 'down'
//   down       : direction of the current element
//   addr       : current address
//   last       : addr is the final address for direction 'down'
module mbist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? '1 : '0;
        end else if (step) begin
            addr_d = down ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = down ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
// March C- memory BIST controller running three data backgrounds.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : test request (honoured only in IDLE or DONE)
//   bg_code     : {par, pat[1:0], ~pol} to the external pattern decoder
//   exp_data    : decoder output, two cycles after bg_code
//   mem_addr    : memory address
//   mem_we      : write strobe (memory stores exp_data)
//   mem_re      : read strobe (mem_rdata valid next cycle)
//   mem_rdata   : memory read data
//   busy, done  : run in progress / run finished (level)
//   fail        : mismatch seen, valid with done
//   fail_addr, fail_elem, fail_bg : first-failure capture
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [3:0]        bg_code,
    input  logic [DATA_W-1:0] exp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [1:0]        fail_bg
);

    state_e            state_q, state_d;
    elem_e             elem_q, elem_d;
    logic [1:0]        pat_q, pat_d;
    logic              op_idx_q, op_idx_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [1:0]        fail_bg_q, fail_bg_d;

    elem_info_t cur;
    logic       cur_rd;
    logic       cur_pol;
    logic       advance;
    logic       ag_load;
    logic       ag_load_down;
    logic       ag_step;
    logic       addr_last;

    assign cur     = elem_info(elem_q);
    assign cur_rd  = cur.rd[op_idx_q];
    assign cur_pol = cur.pol[op_idx_q];

    mbist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cur.down),
        .addr      (mem_addr),
        .last      (addr_last)
    );

    // Each operation walks SETUP -> WAIT -> OP (-> CMP for reads); when one
    // completes, 'advance' picks the next op, address, element or background.
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        pat_d        = pat_q;
        op_idx_d     = op_idx_q;
        exp_d        = exp_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_bg_d    = fail_bg_q;
        advance      = 1'b0;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_SETUP;
                    elem_d       = E0;
                    pat_d        = PAT_SOLID;
                    op_idx_d     = 1'b0;
                    fail_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_elem_d  = '0;
                    fail_bg_d    = '0;
                    ag_load      = 1'b1;
                    ag_load_down = 1'b0;
                end
            end
            ST_SETUP: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_OP;
            ST_OP: begin
                if (cur_rd) begin
                    exp_d   = exp_data;
                    state_d = ST_CMP;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_CMP: begin
                if (mem_rdata != exp_q) begin
                    fail_d      = 1'b1;
                    fail_addr_d = mem_addr;
                    fail_elem_d = elem_q;
                    fail_bg_d   = pat_q;
                    state_d     = ST_DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            state_d = ST_SETUP;
            if (cur.two_ops && !op_idx_q) begin
                op_idx_d = 1'b1;
            end else begin
                op_idx_d = 1'b0;
                if (!addr_last) begin
                    ag_step = 1'b1;
                end else if (elem_q != E5) begin
                    elem_d       = elem_e'(elem_q + 3'd1);
                    ag_load      = 1'b1;
                    ag_load_down = elem_down(elem_d);
                end else if (pat_q != PAT_LAST) begin
                    pat_d        = pat_q + 2'd1;
                    elem_d       = E0;
                    ag_load      = 1'b1;
                    ag_load_down = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= E0;
            pat_q       <= PAT_SOLID;
            op_idx_q    <= 1'b0;
            exp_q       <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bg_q   <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            pat_q       <= pat_d;
            op_idx_q    <= op_idx_d;
            exp_q       <= exp_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_bg_q   <= fail_bg_d;
        end
    end

    assign busy   = (state_q == ST_SETUP) || (state_q == ST_WAIT) ||
                    (state_q == ST_OP)    || (state_q == ST_CMP);
    assign done   = (state_q == ST_DONE);
    assign mem_we = (state_q == ST_OP) && !cur_rd;
    assign mem_re = (state_q == ST_OP) && cur_rd;

    // Solid background ignores address parity; the others alternate with it.
    // bg_code is held steady through SETUP/WAIT/OP to cover decoder latency.
    assign bg_code = busy ? {(pat_q != PAT_SOLID) && mem_addr[0], pat_q, ~cur_pol} : 4'b0000;

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_bg   = fail_bg_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl
// Directed bench for mbist_march_ctrl with a behavioural 2-cycle pattern
// decoder and a 256x4 memory that can model a stuck-at-1 on bit 0 of 0x05.
module tb_mbist_march_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] bg_code;
    logic [3:0] exp_data;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] fail_addr;
    logic [2:0] fail_elem;
    logic [1:0] fail_bg;

    int checks   = 0;
    int failures = 0;
    int busy_total = 0;
    int strobe_err = 0;
    int base;
    int idx;
    int n;

    logic       stuck_en = 1'b0;
    logic [3:0] dec1;
    logic [3:0] mem [0:255];

    mbist_march_ctrl #(
        .ADDR_W (8),
        .DATA_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bg_code   (bg_code),
        .exp_data  (exp_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_bg   (fail_bg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder: base nibble per pattern, inverted by parity and by polarity.
    function automatic logic [3:0] decode(input logic [3:0] code);
        logic [3:0] b;
        case (code[2:1])
            2'd1:    b = 4'b0101;
            2'd2:    b = 4'b0011;
            default: b = 4'b0000;
        endcase
        return b ^ {4{code[3]}} ^ {4{~code[0]}};
    endfunction

    always @(posedge clk) begin
        dec1     <= decode(bg_code);
        exp_data <= dec1;
    end

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= exp_data | ((stuck_en && mem_addr == 8'h05) ? 4'b0001 : 4'b0000);
        if (mem_re)
            mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (busy) busy_total <= busy_total + 1;
    end

    always @(negedge clk) begin
        if (rst_n && ((mem_we && mem_re) || ((mem_we || mem_re) && !busy)))
            strobe_err <= strobe_err + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #23;
        checks++;
        if ({bg_code, mem_addr, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem, fail_bg} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b fail=%b addr=%h bg=%b required all 0",
                     busy, done, fail, mem_addr, bg_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_march_pass();
        base = busy_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30000) begin
            idx = busy_total - base;
            if (idx == 768) begin
                checks++;
                if (bg_code !== 4'b0001 || mem_addr !== 8'h00) begin
                    failures++;
                    $display("[TB] FAIL e1_r0_setup bg=%b addr=%h required 0001/00", bg_code, mem_addr);
                end
            end
            if (idx == 770) begin
                checks++;
                if ({mem_we, mem_re} !== 2'b01) begin
                    failures++;
                    $display("[TB] FAIL e1_read_op we/re=%b%b required 01", mem_we, mem_re);
                end
            end
            if (idx == 772) begin
                checks++;
                if (bg_code !== 4'b0000 || mem_addr !== 8'h00) begin
                    failures++;
                    $display("[TB] FAIL e1_w1_setup bg=%b addr=%h required 0000/00", bg_code, mem_addr);
                end
            end
            if (idx == 2553) begin
                checks++;
                if (mem_addr !== 8'hFF) begin
                    failures++;
                    $display("[TB] FAIL e1_top_addr addr=%h required ff", mem_addr);
                end
            end
            if (idx == 2560) begin
                checks++;
                if (mem_addr !== 8'h00 || bg_code !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL e2_wrap addr=%h bg=%b required 00/0000", mem_addr, bg_code);
                end
            end
            if (idx == 4352) begin
                checks++;
                if (mem_addr !== 8'hFF || bg_code !== 4'b0001) begin
                    failures++;
                    $display("[TB] FAIL e3_down_start addr=%h bg=%b required ff/0001", mem_addr, bg_code);
                end
            end
            if (idx == 8969) begin
                checks++;
                if (bg_code !== 4'b1011 || mem_addr !== 8'h03) begin
                    failures++;
                    $display("[TB] FAIL pat1_bg_code bg=%b addr=%h required 1011/03", bg_code, mem_addr);
                end
            end
            if (idx == 8971) begin
                checks++;
                if (exp_data !== 4'b1010 || mem_we !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL pat1_exp_data exp=%b we=%b required 1010/1", exp_data, mem_we);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pass_timeout done=%b required 1", done);
        end
        checks++;
        if (busy_total - base !== 26880) begin
            failures++;
            $display("[TB] FAIL pass_length got=%0d required 26880", busy_total - base);
        end
        checks++;
        if (fail !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pass_result fail=%b busy=%b required 0/0", fail, busy);
        end
    endtask

    task automatic test_stuck_fault();
        stuck_en = 1'b1;
        base = busy_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, fail, busy} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL restart_from_done done/fail/busy=%b%b%b required 001", done, fail, busy);
        end
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fail !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fault_flag fail=%b done=%b busy=%b required 1/1/0", fail, done, busy);
        end
        checks++;
        if (fail_addr !== 8'h05 || fail_elem !== 3'd1 || fail_bg !== 2'd0) begin
            failures++;
            $display("[TB] FAIL fault_capture addr=%h elem=%0d bg=%0d required 05/1/0",
                     fail_addr, fail_elem, fail_bg);
        end
        checks++;
        if (busy_total - base !== 807) begin
            failures++;
            $display("[TB] FAIL fault_abort_length got=%0d required 807", busy_total - base);
        end
        stuck_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        base = busy_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (fail !== 1'b0 || fail_addr !== 8'h00) begin
            failures++;
            $display("[TB] FAIL start_clears_fail fail=%b addr=%h required 0/00", fail, fail_addr);
        end
        n = 0;
        while ((busy_total - base) < 4400 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bg_code, mem_addr, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem, fail_bg} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_e3 busy=%b done=%b addr=%h bg=%b we=%b re=%b required all 0",
                     busy, done, mem_addr, bg_code, mem_we, mem_re);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_discards_run busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_start_ignored();
        base = busy_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30000) begin
            start = ((busy_total - base) == 100);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || fail !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rerun_result done=%b fail=%b required 1/0", done, fail);
        end
        checks++;
        if (busy_total - base !== 26880) begin
            failures++;
            $display("[TB] FAIL start_ignored_length got=%0d required 26880", busy_total - base);
        end
        checks++;
        if (strobe_err !== 0) begin
            failures++;
            $display("[TB] FAIL strobe_rules got=%0d violations required 0", strobe_err);
        end
    endtask

    initial begin
        test_reset();
        test_march_pass();
        test_stuck_fault();
        test_reset_mid_run();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
